lsu_unit: RTL and testbench

Load/store unit directly downstream of alu_design in the RV32I datapath. Takes the ALU result as the effective address for load/store instructions and runs a single memory transaction over a req/ack handshake. Performs byte-lane steering and byte-enable generation for stores, and extraction plus sign/zero extension for loads. Reports completion, or a fault for a misaligned access, an illegal funct3 or a memory timeout.

---
 rtl/lsu_unit_pkg.sv | 38 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_unit.sv | 142 ++++++++++++++
 tb/tb_lsu_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
// rtl/lsu_unit_pkg.sv - shared encodings and op-decode helpers for the RV32I load/store unit
// Purpose: funct3 width/sign encodings, LSU state type and the legality /
//          alignment rules used when an op is accepted in IDLE.
// Ports:   none (package).
package lsu_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic legal_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] carries the access size for both loads and stores
  // (00 byte, 01 half, 10 word), so one rule covers both.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) ||
           ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering for stores and extract/extend for loads
// Purpose: store byte enables + lane-replicated write data; load lane
//          extraction with sign/zero extension.
// Ports:   funct3, lane (addr[1:0]), is_store, store_data, rdata in;
//          be, wdata, load_ext out.
module lsu_align
  import lsu_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    be    = 4'b1111;
    wdata = 32'd0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << lane;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be    = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    byte_val = 8'd0;
    case (lane)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = lane[1] ? rdata[31:16] : rdata[15:0];
    load_ext = rdata;
    case (funct3)
      F3_LB:   load_ext = {{24{byte_val[7]}}, byte_val};
      F3_LH:   load_ext = {{16{half_val[15]}}, half_val};
      F3_LBU:  load_ext = {24'd0, byte_val};
      F3_LHU:  load_ext = {16'd0, half_val};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - RV32I load/store unit: one memory transaction per op over req/ack
// Purpose: accepts an op in IDLE, checks legality/alignment, runs one
//          req/ack access with an optional timeout, reports done/err.
// Ports:   clk, rst_n, start, is_load, is_store, funct3, addr, store_data in;
//          busy, done, err, load_data out; mem_req, mem_we, mem_addr,
//          mem_wdata, mem_be out; mem_rdata, mem_ack in.
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  lsu_state_t  state;
  logic [2:0]  op_f3;
  logic [1:0]  op_lane;
  logic        op_load;
  logic [31:0] tmo_cnt;

  logic        op_valid;
  logic [2:0]  al_f3;
  logic [1:0]  al_lane;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign op_valid = (is_load ^ is_store) &&
                    (is_load ? legal_load(funct3) : legal_store(funct3)) &&
                    !misaligned(funct3, addr[1:0]);

  // The aligner serves the incoming op while IDLE (store steering) and the
  // latched op while waiting for ack (load extraction), so one copy suffices.
  assign al_f3   = (state == ST_IDLE) ? funct3     : op_f3;
  assign al_lane = (state == ST_IDLE) ? addr[1:0]  : op_lane;

  lsu_align u_align (
    .funct3     (al_f3),
    .lane       (al_lane),
    .is_store   (is_store),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_ext   (al_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      op_f3     <= 3'd0;
      op_lane   <= 2'd0;
      op_load   <= 1'b0;
      tmo_cnt   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (!op_valid) begin
              // Faulted ops never touch memory; report straight away.
              state <= ST_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
              op_f3     <= funct3;
              op_lane   <= addr[1:0];
              op_load   <= is_load;
              tmo_cnt   <= 32'd0;
            end
          end
        end
        ST_REQ: begin
          // An ack on the same edge as the timeout wins.
          if (mem_ack) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            if (op_load) load_data <= al_load;
          end else if ((TIMEOUT != 0) && (tmo_cnt == TIMEOUT - 1)) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - self-checking bench for lsu_unit against a behavioural model
module tb_lsu_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_load_data;
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (done) check("done_twice", {31'd0, prev_done}, 32'd0);
    prev_done = done;
  end

  // Access size in bytes implied by the op, 0 when the op is illegal.
  function automatic int op_size(input bit ld, input bit st, input logic [2:0] f3);
    if (ld == st) return 0;
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      if (f3 == 3'd2) return 4;
      return 0;
    end
    if (f3 <= 3'd2) return 1 << f3;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    logic [31:0] raw, v;
    raw = rd >> (8 * (a % 4));
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = raw & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = raw & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int d, input bit poke);
    int sz, edges, off;
    bit ok, got_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    sz = op_size(ld, st, f3);
    ok = (sz != 0) && ((a % sz) == 0);
    off = a % 4;
    e_be = 4'b0;
    e_wd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (ld || (i >= off && i < off + sz)) e_be[i] = 1'b1;
      if (st && sz != 0) e_wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    end
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    if (!ok) begin
      check("err_no_req", {31'd0, mem_req}, 32'd0);
      check("err_done", {30'd0, done, err}, 32'd3);
      check("err_load_data", load_data, exp_load_data);
    end else begin
      check("req", {31'd0, mem_req}, 32'd1);
      check("we", {31'd0, mem_we}, {31'd0, st});
      check("addr", mem_addr, a & 32'hFFFF_FFFC);
      check("be", {28'd0, mem_be}, {28'd0, e_be});
      if (st) check("wdata", mem_wdata, e_wd);
      got_req = 1'b0;
      edges = 0;
      for (int k = 0; k < 20; k++) begin
        mem_ack = (k == d);
        mem_rdata = (k == d) ? rd : $urandom;
        if (poke && k == 0) begin
          start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        start = 1'b0;
        edges = k + 1;
        if (!mem_req) begin got_req = 1'b1; break; end
        check("req_hold_done", {31'd0, done}, 32'd0);
      end
      if (!got_req) check("req_never_dropped", 32'd1, 32'd0);
      check("latency", edges, (d < TMO) ? d + 1 : TMO);
      if (d < TMO) begin
        check("ok_done", {30'd0, done, err}, 32'd2);
        if (ld) exp_load_data = ref_load(f3, a, rd);
      end else begin
        check("tmo_done", {30'd0, done, err}, 32'd3);
      end
      check("load_data", load_data, exp_load_data);
    end
    @(negedge clk);
    check("idle_done", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check("idle_no_req", {30'd0, mem_req, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0; exp_load_data = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_outs", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
    check("rst_misc", load_data | mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 2, 0);
    do_op(0, 1, 3'd0, 32'h103, 32'h000000A5, 32'd0, 0, 0);
    do_op(0, 1, 3'd1, 32'h102, 32'h00001234, 32'd0, 1, 0);
    do_op(1, 0, 3'd0, 32'h201, 32'd0, 32'h0000F000, 1, 0);
    do_op(1, 0, 3'd4, 32'h201, 32'd0, 32'h0000F000, 0, 0);
    do_op(1, 0, 3'd1, 32'h202, 32'd0, 32'h80000000, 3, 0);
    do_op(1, 0, 3'd2, 32'h102, 32'd0, 32'd0, 0, 0);
    do_op(1, 0, 3'd3, 32'h100, 32'd0, 32'd0, 0, 0);
    do_op(1, 1, 3'd2, 32'h100, 32'd0, 32'd0, 0, 0);
    do_op(1, 0, 3'd2, 32'h300, 32'd0, 32'h12345678, 99, 1);

    for (int t = 0; t < 150; t++) begin
      bit ld, st;
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      ld = (sel < 5) || (sel == 9);
      st = (sel >= 5);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(ld, st, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
            $urandom_range(0, TMO + 1), ($urandom_range(0, 3) == 0));
    end

    // Reset while a request is outstanding, then a late ack.
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst", {29'd0, mem_req, busy, done}, 32'd0);
    exp_load_data = 32'd0;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk);
      check("late_ack", {29'd0, mem_req, busy, done}, 32'd0);
    end
    mem_ack = 1'b0;
    check("late_ack_data", load_data, exp_load_data);
    do_op(1, 0, 3'd5, 32'h602, 32'd0, 32'h9ABC0000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
